// File: rtl/dm_mem_responder.sv
// -----------------------------------------------------------------------------
// dm_mem_responder
//
// Memory-side responder for the level-held Mem_R / Mem_W / Valid protocol.
// Each request is captured in IDLE, held for LATENCY wait-state cycles, then
// completed in RESP with a one-cycle Valid pulse. Reads return the addressed
// word shifted right by the byte offset; writes update only the in-word bytes
// selected by (mask << offset) at the edge that closes RESP.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous active-high reset (aborts any access in flight)
//   Mem_R      read request, held until Valid
//   Mem_W      write byte mask, unshifted; nonzero means write
//   Mem_Addr   byte address
//   Mem_WData  write data, right-justified
//   Mem_RData  read data, right-justified; meaningful while Valid is high
//   Valid      one-cycle completion pulse
//   Busy       high whenever the responder is not IDLE
// -----------------------------------------------------------------------------
module dm_mem_responder #(
  parameter int memAddrWidth = 15,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Mem_R,
  input  logic [3:0]              Mem_W,
  input  logic [memAddrWidth-1:0] Mem_Addr,
  input  logic [31:0]             Mem_WData,
  output logic [31:0]             Mem_RData,
  output logic                    Valid,
  output logic                    Busy
);

  localparam int IDX_W = memAddrWidth - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       rd_fire;
  logic       wr_fire;

  // Request captured at accept
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       off_p0;
  logic [3:0]       mask_p0;
  logic [31:0]      wdata_p0;
  logic             wr_p0;

  logic [31:0] mem [DEPTH];

  // Lane steering: bits pushed past byte 3 fall off, there is no wrap into
  // the following word.
  function automatic logic [3:0] lane_mask(input logic [3:0] m, input logic [1:0] off);
    logic [3:0] r;
    r = m << off;
    return r;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] lane_rdata(input logic [31:0] w, input logic [1:0] off);
    return w >> {off, 3'b000};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_R || (|Mem_W)) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          rd_fire   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      // The request still held during RESP is the one just completed, so
      // RESP never accepts; a held request is taken again from IDLE.
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Valid   = (state == RESP);
  assign Busy    = (state != IDLE);
  assign wr_fire = (state == RESP) && wr_p0 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      Mem_RData <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Read buffer loads before any write of this access, so a write
      // (or a combined R+W) returns the pre-write word.
      if (rd_fire) begin
        Mem_RData <= lane_rdata(mem[idx_p0], off_p0);
      end
    end
  end

  // ---- accept stage: request capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= Mem_Addr[memAddrWidth-1:2];
      off_p0   <= Mem_Addr[1:0];
      mask_p0  <= Mem_W;
      wdata_p0 <= Mem_WData;
      wr_p0    <= |Mem_W;
    end
  end

  // ---- response stage: byte-masked array write ----
  logic [3:0]  wr_lanes;
  logic [31:0] wr_bytes;

  assign wr_lanes = lane_mask(mask_p0, off_p0);
  assign wr_bytes = lane_wdata(wdata_p0, off_p0);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) begin
          mem[idx_p0][8*b +: 8] <= wr_bytes[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_mem_responder.sv
module tb_dm_mem_responder;

  logic        clk;
  logic        rst;
  logic        Mem_R;
  logic [3:0]  Mem_W;
  logic [14:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Valid;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  dm_mem_responder #(.memAddrWidth(15), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .Mem_R     (Mem_R),
    .Mem_W     (Mem_W),
    .Mem_Addr  (Mem_Addr),
    .Mem_WData (Mem_WData),
    .Mem_RData (Mem_RData),
    .Valid     (Valid),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge in an IDLE cycle (cycle A).
  // Returns one cycle after the Valid pulse, again 1 unit after an edge.
  task automatic access(input string tag, input logic r, input logic [3:0] w,
                        input logic [14:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    int   n;
    logic seen;
    Mem_R = r; Mem_W = w; Mem_Addr = a; Mem_WData = d;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (Valid) seen = 1'b1;
      else check({tag, "_busy"}, 32'(Busy), 32'd1);
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_busy_resp"}, 32'(Busy), 32'd1);
    rd = Mem_RData;
    Mem_R = 1'b0; Mem_W = 4'd0;
    @(posedge clk); #1;
    check({tag, "_vld_once"}, 32'(Valid), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  logic [31:0] rd;
  logic [14:0] bb_addr [3];
  logic [31:0] bb_data [3];
  int          vc [3];
  logic [31:0] vd [3];
  int          nv;
  logic        pend;
  logic        saw_valid;

  initial begin
    rst = 1'b1; Mem_R = 1'b0; Mem_W = 4'd0; Mem_Addr = '0; Mem_WData = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_rdata", Mem_RData, 32'd0);
    rst = 1'b0;

    // Word write then read
    access("wr_word", 1'b0, 4'b1111, 15'h0010, 32'hDEADBEEF, rd);
    access("rd_word", 1'b1, 4'b0000, 15'h0010, 32'h0, rd);
    check("rd_word_data", rd, 32'hDEADBEEF);

    // Byte / half lanes
    access("pre_20", 1'b0, 4'b1111, 15'h0020, 32'h11223344, rd);
    access("wr_byte", 1'b0, 4'b0001, 15'h0022, 32'h000000AA, rd);
    access("rd_20", 1'b1, 4'b0000, 15'h0020, 32'h0, rd);
    check("byte_merge", rd, 32'h11AA3344);
    access("rd_half", 1'b1, 4'b0000, 15'h0022, 32'h0, rd);
    check("half_read", rd, 32'h000011AA);

    // Back-to-back with Mem_R held
    bb_addr[0] = 15'h0100; bb_addr[1] = 15'h0104; bb_addr[2] = 15'h0108;
    bb_data[0] = 32'hA0A00001; bb_data[1] = 32'hB0B00002; bb_data[2] = 32'hC0C00003;
    for (int i = 0; i < 3; i++) access("pre_bb", 1'b0, 4'b1111, bb_addr[i], bb_data[i], rd);
    Mem_R = 1'b1; Mem_Addr = bb_addr[0];
    nv = 0; pend = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (pend) begin
        pend = 1'b0;
        if (nv < 3) Mem_Addr = bb_addr[nv];
        else Mem_R = 1'b0;
      end
      if (Valid) begin
        if (nv < 3) begin vc[nv] = c; vd[nv] = Mem_RData; end
        nv++;
        pend = 1'b1;
      end
    end
    Mem_R = 1'b0;
    check("bb_count", 32'(nv), 32'd3);
    check("bb_cyc0", 32'(vc[0]), 32'd3);
    check("bb_cyc1", 32'(vc[1]), 32'd7);
    check("bb_cyc2", 32'(vc[2]), 32'd11);
    check("bb_data0", vd[0], 32'hA0A00001);
    check("bb_data1", vd[1], 32'hB0B00002);
    check("bb_data2", vd[2], 32'hC0C00003);

    // Simultaneous read and write returns the old word
    access("pre_30", 1'b0, 4'b1111, 15'h0030, 32'h00000009, rd);
    access("rw_30", 1'b1, 4'b1111, 15'h0030, 32'h00000005, rd);
    check("rw_old", rd, 32'h00000009);
    access("rd_30", 1'b1, 4'b0000, 15'h0030, 32'h0, rd);
    check("rw_new", rd, 32'h00000005);

    // Misaligned half write at offset 3
    access("pre_50", 1'b0, 4'b1111, 15'h0050, 32'h00000000, rd);
    access("pre_54", 1'b0, 4'b1111, 15'h0054, 32'h12345678, rd);
    access("wr_mis", 1'b0, 4'b0011, 15'h0053, 32'h0000BEEF, rd);
    access("rd_50", 1'b1, 4'b0000, 15'h0050, 32'h0, rd);
    check("mis_word", rd, 32'hEF000000);
    access("rd_54", 1'b1, 4'b0000, 15'h0054, 32'h0, rd);
    check("mis_next", rd, 32'h12345678);

    // Reset during BUSY of a write aborts it
    access("pre_40", 1'b0, 4'b1111, 15'h0040, 32'h00000001, rd);
    Mem_W = 4'b1111; Mem_Addr = 15'h0040; Mem_WData = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("abort_busy_pre", 32'(Busy), 32'd1);
    rst = 1'b1; Mem_W = 4'd0;
    @(posedge clk); #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_valid", 32'(Valid), 32'd0);
    check("abort_rdata", Mem_RData, 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (Valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    access("rd_40", 1'b1, 4'b0000, 15'h0040, 32'h0, rd);
    check("abort_kept", rd, 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_mem_responder.md
# dm_mem_responder

Memory-side responder for the pipeline controller's level-held memory request protocol (`Mem_R` / `Mem_W[3:0]` / `Valid`). It serves one instruction or data port. It captures each request, waits a programmable number of wait-state cycles, and performs a byte-masked write or a word read on an internal word array. It then pulses `Valid` for one cycle. Two instances (IM and DM) sit between the CPU core and the memory array and stand in for cache/SRAM latency.

## Interface
Parameters:
- `memAddrWidth`, 15: byte-address width. Array depth is 2^(memAddrWidth-2) 32-bit words.
- `LATENCY`, 2: wait-state cycles between accept and response. Legal range 1..15.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Mem_R`  in  1  read request, held high until `Valid` is seen.
- `Mem_W`  in  4  write byte mask, unshifted (0001 byte, 0011 half, 1111 word). Nonzero means a write request.
- `Mem_Addr`  in  memAddrWidth  byte address.
- `Mem_WData`  in  32  write data, right-justified (addressed byte in bits [7:0]).
- `Mem_RData`  out  32  read data, right-justified.
- `Valid`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high while not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `Mem_R` or any `Mem_W` bit is high, accept the request:
    - latch word index `Mem_Addr[memAddrWidth-1:2]`, offset `Mem_Addr[1:0]`, mask, write data, and type;
    - set cnt = LATENCY-1;
    - go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt == 0, register the array word at the latched index into a read buffer and go to RESP.
  - Otherwise decrement cnt.
  - Input changes during BUSY are ignored; a captured access always completes.
- RESP:
  - `Valid` = 1.
  - `Mem_RData` = read buffer >> (8 × offset), zero-filled.
  - If it is a write, at the closing edge update bytes where (mask << offset) is set with (WData << 8 × offset). `Mem_RData` still shows the pre-write word.
  - Next state is always IDLE. The request still visible during RESP is the completed one and is not re-accepted.
- `Mem_R` and `Mem_W` both set: treated as a write; the read data returned is the old word.
- Misaligned access (e.g. half at offset 3): mask and data bits shifted past byte 3 are dropped. Only the in-word bytes are written; no wrap to the next word.
- Address wrap: index bits above the array depth do not exist. The index is exactly `memAddrWidth-2` bits wide, so the top address aliases naturally.
- `cnt` width is 4 bits.

## Timing
- Reset values: state IDLE, cnt 0, `Valid` 0, `Busy` 0, `Mem_RData` 0 (read buffer cleared). Array contents are not cleared.
- Reset asserted mid-access (BUSY or RESP) aborts the access. No array write occurs, and the block is IDLE with `Valid` 0 on the next cycle.
- Request first high in IDLE at cycle A → `Valid` high during cycle A+LATENCY+1 → IDLE at A+LATENCY+2.
- Minimum spacing between back-to-back accesses is LATENCY+2 cycles. A request held high through RESP is accepted at cycle A+LATENCY+2 as a new access.
- `Busy` is high during cycles A+1 .. A+LATENCY+1.
- `Mem_RData` is valid only while `Valid` = 1. It holds its last value otherwise.
- Write data becomes visible to an access accepted at A+LATENCY+2 or later.

## Test plan
- Word write then read, LATENCY=2:
  - write 0xDEADBEEF to addr 0x0010, mask 1111 → `Valid` at A+3;
  - read 0x0010 → `Mem_RData` = 0xDEADBEEF, `Valid` exactly one cycle.
- Byte/half lanes:
  - preload 0x11223344 at 0x0020;
  - byte write 0xAA at 0x0022 → word becomes 0x11AA3344;
  - half read at 0x0022 → `Mem_RData` = 0x000011AA.
- Back-to-back: `Mem_R` held high for 3 consecutive addresses with the address changed the cycle after each `Valid` → `Valid` pulses at A+3, A+7, A+11; no duplicate accept.
- Simultaneous R and W: `Mem_R`=1, `Mem_W`=1111, WData 0x5 at 0x0030 (old 0x9) → `Mem_RData` = 0x9; a later read returns 0x5.
- Misaligned half write 0xBEEF at offset 3 over 0x00000000 → word = 0xEF000000; the next word is unchanged.
- Reset during BUSY of a write to 0x0040 (old 0x1) → `Valid` never pulses, `Busy` 0 the next cycle; a later read of 0x0040 returns 0x1.
